// File: rtl/decoder_nx2n_scan_if.sv
// ---------------------------------------------------------------------------
// decoder_nx2n_scan_if
// Bundles the control inputs and decoded outputs of decoder_nx2n_scan.
//   enable : 1 = decode, 0 = outputs inactive and state frozen
//   mode   : 0 = direct decode of sel, 1 = auto-scan
//   sel    : direct-mode address / scan-mode load value
//   load   : scan mode only, restart the scan at sel
//   D      : one-hot decode, D[0] is position 0 (ascending range)
//   idx    : currently active index
//   wrap   : one-cycle pulse when the scan index wraps OUTS-1 -> 0
// master drives the controls, slave (the decoder) drives the outputs.
// ---------------------------------------------------------------------------
interface decoder_nx2n_scan_if #(
    parameter int SEL_W = 2
);
    localparam int OUTS = 1 << SEL_W;

    logic             enable;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic             load;
    logic [0:OUTS-1]  D;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    modport master (
        output enable, mode, sel, load,
        input  D, idx, wrap
    );

    modport slave (
        input  enable, mode, sel, load,
        output D, idx, wrap
    );
endinterface

// File: rtl/decoder_nx2n_scan.sv
// ---------------------------------------------------------------------------
// decoder_nx2n_scan
// Registered N-to-2^N one-hot decoder with enable and an auto-scan mode that
// steps the active output through every position, each held for DWELL
// cycles (digit multiplexing / row strobing).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : decoder_nx2n_scan_if.slave (enable, mode, sel, load, D, idx, wrap)
// Parameters:
//   SEL_W      : select width, OUTS = 2**SEL_W outputs
//   DWELL      : cycles per position in scan mode (1..65535)
//   ACTIVE_LOW : 1 inverts D (active position reads 0)
// ---------------------------------------------------------------------------
module decoder_nx2n_scan #(
    parameter int SEL_W      = 2,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input logic                  clk,
    input logic                  rst,
    decoder_nx2n_scan_if.slave   bus
);
    localparam int OUTS  = 1 << SEL_W;
    // A single-cycle dwell still needs a 1-bit counter so the width is legal.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(DWELL - 1);
    localparam logic [0:OUTS-1]   INACTIVE   = {OUTS{ACTIVE_LOW != 0}};

    logic [0:OUTS-1]   r_d;
    logic [SEL_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wrap;

    logic [SEL_W-1:0]  w_nextIdx;
    logic              w_dwellDone;

    // Builds the output pattern for one active position; every SEL_W value
    // maps to a real position, so no value can produce an unknown output.
    function automatic logic [0:OUTS-1] decode(input logic [SEL_W-1:0] a);
        logic [0:OUTS-1] v;
        v    = '0;
        v[a] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~v : v;
    endfunction

    // The increment wraps naturally at OUTS because idx is exactly SEL_W bits.
    assign w_nextIdx   = r_idx + 1'b1;
    assign w_dwellDone = (r_cnt == LAST_COUNT);

    // Single register block: reset beats disable, disable beats load, load
    // beats a scan advance. D is decoded from the next idx so the active
    // position always matches idx one cycle after an enabled edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d    <= INACTIVE;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (!bus.enable) begin
            r_d    <= INACTIVE;
            r_wrap <= 1'b0;
        end else if (!bus.mode || bus.load) begin
            r_d    <= decode(bus.sel);
            r_idx  <= bus.sel;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (w_dwellDone) begin
            r_d    <= decode(w_nextIdx);
            r_idx  <= w_nextIdx;
            r_cnt  <= '0;
            r_wrap <= (w_nextIdx == '0);
        end else begin
            r_d    <= decode(r_idx);
            r_cnt  <= r_cnt + 1'b1;
            r_wrap <= 1'b0;
        end
    end

    assign bus.D    = r_d;
    assign bus.idx  = r_idx;
    assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// ---------------------------------------------------------------------------
// tb_decoder_nx2n_scan
// Drives two decoders side by side: A (SEL_W=2, DWELL=4, active high) and
// B (SEL_W=3, DWELL=1, active low). A reference model describes the scan
// as "start position plus elapsed enabled scan cycles divided by DWELL",
// and every clock both DUTs are compared against it.
// ---------------------------------------------------------------------------
module tb_decoder_nx2n_scan;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int compared   = 0;
    int mismatched = 0;
    int wrapsSeen;

    typedef struct {
        int start;
        int cycles;
        bit on;
        bit wrap;
    } model_t;

    model_t mA;
    model_t mB;

    decoder_nx2n_scan_if #(.SEL_W(2)) busA ();
    decoder_nx2n_scan_if #(.SEL_W(3)) busB ();

    decoder_nx2n_scan #(.SEL_W(2), .DWELL(4), .ACTIVE_LOW(0)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    decoder_nx2n_scan #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Active index: the scan started at 'start' and has spent 'cycles'
    // enabled scan cycles, DWELL of them per position.
    function automatic int modelIdx(model_t m, int dwell, int outs);
        return (m.start + m.cycles / dwell) % outs;
    endfunction

    // One clock edge of the reference behaviour.
    function automatic model_t modelStep(model_t m, bit r, bit en, bit md, bit ld,
                                         int s, int dwell, int outs);
        model_t n;
        n = m;
        if (r) begin
            n.start = 0; n.cycles = 0; n.on = 0; n.wrap = 0;
        end else if (!en) begin
            n.on = 0; n.wrap = 0;
        end else if (!md || ld) begin
            n.start = s; n.cycles = 0; n.on = 1; n.wrap = 0;
        end else begin
            n.cycles = m.cycles + 1;
            n.on     = 1;
            n.wrap   = ((n.cycles % dwell) == 0) && (modelIdx(n, dwell, outs) == 0);
        end
        return n;
    endfunction

    // Counts one comparison and reports it if it does not match.
    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(bit en, bit md, bit ld, int sA, int sB);
        busA.enable = en; busA.mode = md; busA.load = ld; busA.sel = 2'(sA);
        busB.enable = en; busB.mode = md; busB.load = ld; busB.sel = 3'(sB);
    endtask

    // Compares both DUTs against the model state for the edge just taken.
    task automatic checkOutput(string tag);
        logic [0:3] expA;
        logic [0:7] expB;
        int ia;
        int ib;
        ia = modelIdx(mA, 4, 4);
        ib = modelIdx(mB, 1, 8);
        for (int k = 0; k < 4; k++) expA[k] = mA.on && (k == ia);
        for (int k = 0; k < 8; k++) expB[k] = !(mB.on && (k == ib));
        cmp({tag, ".A.D"},    32'(busA.D),    32'(expA));
        cmp({tag, ".A.idx"},  32'(busA.idx),  32'(ia));
        cmp({tag, ".A.wrap"}, 32'(busA.wrap), 32'(mA.wrap));
        cmp({tag, ".B.D"},    32'(busB.D),    32'(expB));
        cmp({tag, ".B.idx"},  32'(busB.idx),  32'(ib));
        cmp({tag, ".B.wrap"}, 32'(busB.wrap), 32'(mB.wrap));
        if (mB.on) cmp({tag, ".B.onehot"}, 32'($countones(~busB.D)), 32'd1);
    endtask

    // Advances one clock, steps the model with the inputs seen at the edge,
    // then checks just after the edge.
    task automatic cycle(string tag);
        @(posedge clk);
        mA = modelStep(mA, rst, busA.enable, busA.mode, busA.load, int'(busA.sel), 4, 4);
        mB = modelStep(mB, rst, busB.enable, busB.mode, busB.load, int'(busB.sel), 1, 8);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        mA = '{0, 0, 0, 0};
        mB = '{0, 0, 0, 0};
        applyStimulus(1, 0, 0, 2, 5);

        // Reset state
        rst = 1'b1;
        cycle("reset");
        cmp("reset.A.D.const", 32'(busA.D), 32'h0);
        cmp("reset.B.D.const", 32'(busB.D), 32'hFF);
        rst = 1'b0;

        // Direct decode of every select value
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1, 0, 0, s, s + 4);
            cycle("direct");
        end
        cmp("direct.A.D.const", 32'(busA.D), 32'h1);

        // Disable: outputs inactive, idx held while sel moves
        for (int s = 0; s < 3; s++) begin
            applyStimulus(0, 0, 0, s, s);
            cycle("disable");
        end
        cmp("disable.A.idx.const", 32'(busA.idx), 32'd3);
        applyStimulus(1, 0, 0, 1, 2);
        cycle("reenable");

        // Scan from reset: three full 16-cycle rounds
        rst = 1'b1;
        cycle("rst2");
        rst = 1'b0;
        applyStimulus(1, 1, 0, 0, 0);
        wrapsSeen = 0;
        for (int c = 0; c < 48; c++) begin
            cycle("scan");
            if (busA.wrap) wrapsSeen++;
        end
        cmp("scan.A.wrapcount", 32'(wrapsSeen), 32'd3);

        // Load mid-dwell at idx 1
        rst = 1'b1;
        cycle("rst3");
        rst = 1'b0;
        for (int c = 0; c < 5; c++) cycle("preload");
        applyStimulus(1, 1, 1, 3, 6);
        cycle("load");
        applyStimulus(1, 1, 0, 0, 0);
        for (int c = 0; c < 5; c++) cycle("postload");

        // Load on the same edge as an advance
        for (int c = 0; c < 8 && (mA.cycles % 4) != 3; c++) cycle("toadvance");
        applyStimulus(1, 1, 1, 1, 2);
        cycle("loadadv");
        cmp("loadadv.A.idx.const", 32'(busA.idx), 32'd1);
        applyStimulus(1, 1, 0, 0, 0);
        cycle("afterloadadv");

        // Load ignored in direct mode (sel still wins)
        applyStimulus(1, 0, 1, 2, 3);
        cycle("loaddirect");

        // Freeze at idx 2, count 2, then resume
        rst = 1'b1;
        cycle("rst4");
        rst = 1'b0;
        applyStimulus(1, 1, 0, 0, 0);
        for (int c = 0; c < 10; c++) cycle("tofreeze");
        applyStimulus(0, 1, 0, 0, 0);
        for (int c = 0; c < 5; c++) cycle("frozen");
        applyStimulus(1, 1, 0, 0, 0);
        for (int c = 0; c < 6; c++) cycle("resume");

        // Reset mid-dwell
        rst = 1'b1;
        cycle("rstmid");
        cmp("rstmid.A.idx.const", 32'(busA.idx), 32'd0);
        rst = 1'b0;

        // Randomized mix of all controls
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 11) == 0),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
            cycle("random");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
